pipe_mmio_datamem: RTL and testbench

//  Data memory stage for the pipelined CPU with a parametrised memory-mapped IO window.

---
 rtl/pipe_mmio_datamem_pkg.sv | 50 +++++
 rtl/pipe_mmio_datamem_sw_sync.sv | 45 ++++
 rtl/pipe_mmio_datamem.sv | 144 ++++++++++++++
 tb/tb_pipe_mmio_datamem.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_mmio_datamem_pkg.sv
// Shared definitions for the MEM-stage data memory: IO word offsets,
// address-decode selector and the decode helper used by the top level.
package pipe_mmio_datamem_pkg;

  // Word offsets (addr[7:2]) of the IO registers; the CPU test program
  // uses the same numbers.
  localparam int IO_HEX_BASE = 32;
  localparam int IO_SW       = 48;
  localparam int IO_SWCHG    = 49;
  localparam int IO_CYC      = 50;
  localparam int IO_LED      = 51;

  // Largest legal values of the elaboration parameters.
  localparam int MAX_DEPTH = 32;
  localparam int MAX_HEX   = 16;
  localparam int MAX_W     = 32;

  // Which storage element a word address selects.
  typedef enum logic [2:0] {
    SEL_RAM,
    SEL_HEX,
    SEL_SW,
    SEL_SWCHG,
    SEL_CYC,
    SEL_LED,
    SEL_NONE
  } sel_e;

  // Classify a word address. Words 0..31 are RAM (aliased by the caller),
  // 32..47 are hex digit slots of which only the first n_hex exist.
  function automatic sel_e decode_word(input logic [5:0] w, input int n_hex);
    sel_e s;
    s = SEL_NONE;
    if (!w[5]) begin
      s = SEL_RAM;
    end else if (w[5:4] == 2'b10) begin
      if ({28'b0, w[3:0]} < 32'(n_hex)) s = SEL_HEX;
    end else if (w == 6'(IO_SW)) begin
      s = SEL_SW;
    end else if (w == 6'(IO_SWCHG)) begin
      s = SEL_SWCHG;
    end else if (w == 6'(IO_CYC)) begin
      s = SEL_CYC;
    end else if (w == 6'(IO_LED)) begin
      s = SEL_LED;
    end
    return s;
  endfunction

endpackage

// File: rtl/pipe_mmio_datamem_sw_sync.sv
// Switch input conditioning: two-flop synchroniser, previous-value register
// and a sticky change flag. A new change beats a clear in the same cycle so
// an edge arriving while the CPU acknowledges the old one is never lost.
module pipe_sw_sync #(
  parameter int W = 10
) (
  input  logic         ram_clock,
  input  logic         resetn,
  input  logic [W-1:0] sw,
  input  logic         clr,
  output logic [W-1:0] sw_s,
  output logic         chg
);

  logic [W-1:0] sync1;
  logic [W-1:0] prev;
  logic         changed;

  // Two-flop synchroniser plus the registered copy used for edge detection.
  always_ff @(posedge ram_clock or negedge resetn) begin
    if (!resetn) begin
      sync1 <= '0;
      sw_s  <= '0;
      prev  <= '0;
    end else begin
      sync1 <= sw;
      sw_s  <= sync1;
      prev  <= sw_s;
    end
  end

  assign changed = (sw_s != prev);

  // Sticky change flag: set has priority over clear.
  always_ff @(posedge ram_clock or negedge resetn) begin
    if (!resetn) begin
      chg <= 1'b0;
    end else if (changed) begin
      chg <= 1'b1;
    end else if (clr) begin
      chg <= 1'b0;
    end
  end

endmodule

// File: rtl/pipe_mmio_datamem.sv
// MEM-stage data memory: word RAM plus a memory-mapped IO window holding
// hex digit registers, an LED register, a synchronised switch port with a
// sticky change flag and a free-running cycle counter. Loads are
// combinational; stores and all register updates happen on posedge.
module pipe_mmio_datamem
  import pipe_mmio_datamem_pkg::*;
#(
  parameter int DEPTH = 32,
  parameter int N_HEX = 6,
  parameter int SW_W  = 10,
  parameter int LED_W = 10
) (
  input  logic               ram_clock,
  input  logic               resetn,
  input  logic [31:0]        addr,
  input  logic [31:0]        datain,
  input  logic               we,
  input  logic [SW_W-1:0]    sw,
  output logic [31:0]        dataout,
  output logic [4*N_HEX-1:0] hex,
  output logic [LED_W-1:0]   led,
  output logic               sw_irq
);

  localparam int AW = $clog2(DEPTH);

  generate
    if (DEPTH < 2 || DEPTH > MAX_DEPTH || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
      $error("pipe_mmio_datamem: DEPTH must be a power of 2 in 2..32");
    end
    if (N_HEX < 1 || N_HEX > MAX_HEX) begin : g_bad_hex
      $error("pipe_mmio_datamem: N_HEX must be in 1..16");
    end
    if (SW_W < 1 || SW_W > MAX_W) begin : g_bad_sw
      $error("pipe_mmio_datamem: SW_W must be in 1..32");
    end
    if (LED_W < 1 || LED_W > MAX_W) begin : g_bad_led
      $error("pipe_mmio_datamem: LED_W must be in 1..32");
    end
  endgenerate

  logic [5:0]         word;
  logic [AW-1:0]      ram_idx;
  logic [3:0]         hex_k;
  sel_e               sel;
  logic [31:0]        mem [DEPTH];
  logic [4*N_HEX-1:0] hex_q;
  logic [LED_W-1:0]   led_q;
  logic [31:0]        cyc;
  logic [SW_W-1:0]    sw_s;
  logic               chg;
  logic               chg_clr;
  logic [31:0]        sw_ext;
  logic [31:0]        led_ext;
  logic               unused_bits;

  // addr[1:0] and addr[31:8] are not decoded; upper datain bits reach only
  // the RAM and the counter.
  assign unused_bits = ^{addr, datain};

  assign word    = addr[7:2];
  assign ram_idx = addr[AW+1:2];
  assign hex_k   = word[3:0];
  assign sel     = decode_word(word, N_HEX);
  assign chg_clr = we && (sel == SEL_SWCHG);

  // RAM store; deliberately not reset so contents survive a CPU reset.
  always_ff @(posedge ram_clock) begin
    if (we && sel == SEL_RAM) mem[ram_idx] <= datain;
  end

  // Hex digit registers, one nibble per digit.
  always_ff @(posedge ram_clock or negedge resetn) begin
    if (!resetn) begin
      hex_q <= '0;
    end else if (we && sel == SEL_HEX) begin
      for (int k = 0; k < N_HEX; k++) begin
        if (hex_k == 4'(k)) hex_q[4*k +: 4] <= datain[3:0];
      end
    end
  end

  // LED register.
  always_ff @(posedge ram_clock or negedge resetn) begin
    if (!resetn) begin
      led_q <= '0;
    end else if (we && sel == SEL_LED) begin
      led_q <= datain[LED_W-1:0];
    end
  end

  // Free-running cycle counter; a CPU store replaces that cycle's increment.
  always_ff @(posedge ram_clock or negedge resetn) begin
    if (!resetn) begin
      cyc <= '0;
    end else if (we && sel == SEL_CYC) begin
      cyc <= datain;
    end else begin
      cyc <= cyc + 32'd1;
    end
  end

  pipe_sw_sync #(
    .W(SW_W)
  ) u_sw_sync (
    .ram_clock(ram_clock),
    .resetn   (resetn),
    .sw       (sw),
    .clr      (chg_clr),
    .sw_s     (sw_s),
    .chg      (chg)
  );

  // Zero-extend the narrow IO registers to a full word.
  always_comb begin
    sw_ext  = '0;
    led_ext = '0;
    sw_ext[SW_W-1:0]   = sw_s;
    led_ext[LED_W-1:0] = led_q;
  end

  // Load-data mux; RAM reads see the pre-store value until the edge.
  always_comb begin
    dataout = '0;
    case (sel)
      SEL_RAM:   dataout = mem[ram_idx];
      SEL_HEX: begin
        for (int k = 0; k < N_HEX; k++) begin
          if (hex_k == 4'(k)) dataout = {28'b0, hex_q[4*k +: 4]};
        end
      end
      SEL_SW:    dataout = sw_ext;
      SEL_SWCHG: dataout = {31'b0, chg};
      SEL_CYC:   dataout = cyc;
      SEL_LED:   dataout = led_ext;
      default:   dataout = '0;
    endcase
  end

  assign hex    = hex_q;
  assign led    = led_q;
  assign sw_irq = chg;

endmodule

// File: tb/tb_pipe_mmio_datamem.sv
// Directed bench for pipe_mmio_datamem (DEPTH=8, N_HEX=6, SW_W=10, LED_W=10).
`timescale 1ns/1ps
module tb_pipe_mmio_datamem;

  logic        ram_clock = 1'b0;
  logic        resetn;
  logic [31:0] addr;
  logic [31:0] datain;
  logic        we;
  logic [9:0]  sw;
  logic [31:0] dataout;
  logic [23:0] hex;
  logic [9:0]  led;
  logic        sw_irq;

  int errors = 0;
  int checks = 0;

  pipe_mmio_datamem #(
    .DEPTH(8),
    .N_HEX(6),
    .SW_W (10),
    .LED_W(10)
  ) dut (
    .ram_clock(ram_clock),
    .resetn   (resetn),
    .addr     (addr),
    .datain   (datain),
    .we       (we),
    .sw       (sw),
    .dataout  (dataout),
    .hex      (hex),
    .led      (led),
    .sw_irq   (sw_irq)
  );

  // Clock: 40 ns period, leaves room for several combinational reads per cycle.
  always #20 ram_clock = ~ram_clock;

  task automatic tick();
    @(posedge ram_clock);
    #1;
  endtask

  task automatic do_write(input logic [31:0] a, input logic [31:0] d);
    addr   = a;
    datain = d;
    we     = 1'b1;
    tick();
    we     = 1'b0;
  endtask

  task automatic rd(input logic [31:0] a, output logic [31:0] d);
    addr = a;
    #1;
    d = dataout;
  endtask

  task automatic test_reset();
    logic [31:0] d;
    resetn = 1'b0;
    repeat (3) tick();
    resetn = 1'b1;
    for (int w = 32; w < 38; w++) begin
      rd(32'(w * 4), d);
      checks++;
      if (d !== 32'h0) begin
        errors++;
        $display("FAIL reset_hex_word%0d: got %h expected %h", w, d, 32'h0);
      end
    end
    rd(32'hCC, d);
    checks++;
    if (d !== 32'h0) begin errors++; $display("FAIL reset_led_read: got %h expected %h", d, 32'h0); end
    rd(32'hC4, d);
    checks++;
    if (d !== 32'h0) begin errors++; $display("FAIL reset_swchg_read: got %h expected %h", d, 32'h0); end
    checks++;
    if (hex !== 24'h0 || led !== 10'h0 || sw_irq !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs: got hex=%h led=%h irq=%b expected 0", hex, led, sw_irq);
    end
    rd(32'hC8, d);
    checks++;
    if (d !== 32'h0) begin errors++; $display("FAIL reset_cyc_start: got %h expected %h", d, 32'h0); end
    repeat (5) tick();
    rd(32'hC8, d);
    checks++;
    if (d !== 32'd5) begin errors++; $display("FAIL reset_cyc_5: got %h expected %h", d, 32'd5); end
  endtask

  task automatic test_ram();
    logic [31:0] d;
    do_write(32'h04, 32'hDEADBEEF);
    rd(32'h04, d);
    checks++;
    if (d !== 32'hDEADBEEF) begin errors++; $display("FAIL ram_word1: got %h expected %h", d, 32'hDEADBEEF); end
    rd(32'h24, d);
    checks++;
    if (d !== 32'hDEADBEEF) begin errors++; $display("FAIL ram_alias: got %h expected %h", d, 32'hDEADBEEF); end
    do_write(32'h08, 32'h11111111);
    addr   = 32'h08;
    datain = 32'h22222222;
    we     = 1'b1;
    #1;
    checks++;
    if (dataout !== 32'h11111111) begin
      errors++;
      $display("FAIL ram_old_before_edge: got %h expected %h", dataout, 32'h11111111);
    end
    tick();
    we = 1'b0;
    rd(32'h08, d);
    checks++;
    if (d !== 32'h22222222) begin errors++; $display("FAIL ram_new_after_edge: got %h expected %h", d, 32'h22222222); end
    rd(32'h04, d);
    checks++;
    if (d !== 32'hDEADBEEF) begin errors++; $display("FAIL ram_word1_kept: got %h expected %h", d, 32'hDEADBEEF); end
  endtask

  task automatic test_hex_led();
    logic [31:0] d;
    do_write(32'h84, 32'h1A3);
    checks++;
    if (hex !== 24'h000030) begin errors++; $display("FAIL hex_digit1: got %h expected %h", hex, 24'h000030); end
    rd(32'h84, d);
    checks++;
    if (d !== 32'h3) begin errors++; $display("FAIL hex_digit1_read: got %h expected %h", d, 32'h3); end
    do_write(32'h80, 32'hFFFF_FFF5);
    checks++;
    if (hex !== 24'h000035) begin errors++; $display("FAIL hex_digit0: got %h expected %h", hex, 24'h000035); end
    do_write(32'h98, 32'h0000000F);
    checks++;
    if (hex !== 24'h000035 || led !== 10'h0 || sw_irq !== 1'b0) begin
      errors++;
      $display("FAIL hex_out_of_range: got hex=%h led=%h irq=%b expected hex=000035 led=000 irq=0", hex, led, sw_irq);
    end
    rd(32'h98, d);
    checks++;
    if (d !== 32'h0) begin errors++; $display("FAIL hex_out_of_range_read: got %h expected %h", d, 32'h0); end
    do_write(32'hCC, 32'hFFFFFFFF);
    checks++;
    if (led !== 10'h3FF) begin errors++; $display("FAIL led_write: got %h expected %h", led, 10'h3FF); end
    rd(32'hCC, d);
    checks++;
    if (d !== 32'h3FF) begin errors++; $display("FAIL led_read: got %h expected %h", d, 32'h3FF); end
    do_write(32'hC0, 32'h3FF);
    rd(32'hC0, d);
    checks++;
    if (d !== 32'h0) begin errors++; $display("FAIL sw_write_ignored: got %h expected %h", d, 32'h0); end
  endtask

  task automatic test_switch();
    logic [31:0] d;
    sw = 10'h155;
    tick();
    rd(32'hC0, d);
    checks++;
    if (d !== 32'h0) begin errors++; $display("FAIL sw_after_1_edge: got %h expected %h", d, 32'h0); end
    tick();
    rd(32'hC0, d);
    checks++;
    if (d !== 32'h155) begin errors++; $display("FAIL sw_after_2_edges: got %h expected %h", d, 32'h155); end
    checks++;
    if (sw_irq !== 1'b0) begin errors++; $display("FAIL irq_not_yet: got %b expected %b", sw_irq, 1'b0); end
    tick();
    checks++;
    if (sw_irq !== 1'b1) begin errors++; $display("FAIL irq_set: got %b expected %b", sw_irq, 1'b1); end
    rd(32'hC4, d);
    checks++;
    if (d !== 32'h1) begin errors++; $display("FAIL swchg_read: got %h expected %h", d, 32'h1); end
    do_write(32'hC4, 32'h0);
    checks++;
    if (sw_irq !== 1'b0) begin errors++; $display("FAIL irq_clear: got %b expected %b", sw_irq, 1'b0); end
  endtask

  task automatic test_set_beats_clear();
    logic [31:0] d;
    sw = 10'h0AA;
    tick();
    sw = 10'h0AB;
    tick();
    tick();
    checks++;
    if (sw_irq !== 1'b1) begin errors++; $display("FAIL irq_set_again: got %b expected %b", sw_irq, 1'b1); end
    rd(32'hC0, d);
    checks++;
    if (d !== 32'h0AB) begin errors++; $display("FAIL sw_second_value: got %h expected %h", d, 32'h0AB); end
    do_write(32'hC4, 32'($urandom_range(0, 255)));
    checks++;
    if (sw_irq !== 1'b1) begin errors++; $display("FAIL set_beats_clear: got %b expected %b", sw_irq, 1'b1); end
    do_write(32'hC4, 32'h0);
    checks++;
    if (sw_irq !== 1'b0) begin errors++; $display("FAIL clear_after_set: got %b expected %b", sw_irq, 1'b0); end
  endtask

  task automatic test_counter_and_reset();
    logic [31:0] d;
    do_write(32'hC8, 32'hFFFFFFFE);
    rd(32'hC8, d);
    checks++;
    if (d !== 32'hFFFFFFFE) begin errors++; $display("FAIL cyc_load: got %h expected %h", d, 32'hFFFFFFFE); end
    tick();
    rd(32'hC8, d);
    checks++;
    if (d !== 32'hFFFFFFFF) begin errors++; $display("FAIL cyc_max: got %h expected %h", d, 32'hFFFFFFFF); end
    tick();
    rd(32'hC8, d);
    checks++;
    if (d !== 32'h0) begin errors++; $display("FAIL cyc_wrap: got %h expected %h", d, 32'h0); end
    tick();
    rd(32'hC8, d);
    checks++;
    if (d !== 32'h1) begin errors++; $display("FAIL cyc_after_wrap: got %h expected %h", d, 32'h1); end
    addr   = 32'hCC;
    datain = 32'h2AA;
    we     = 1'b1;
    resetn = 1'b0;
    #1;
    checks++;
    if (led !== 10'h0 || hex !== 24'h0) begin
      errors++;
      $display("FAIL async_reset: got hex=%h led=%h expected 0", hex, led);
    end
    tick();
    checks++;
    if (led !== 10'h0) begin errors++; $display("FAIL store_during_reset: got %h expected %h", led, 10'h0); end
    we = 1'b0;
    rd(32'hC8, d);
    checks++;
    if (d !== 32'h0) begin errors++; $display("FAIL cyc_in_reset: got %h expected %h", d, 32'h0); end
    rd(32'h04, d);
    checks++;
    if (d !== 32'hDEADBEEF) begin errors++; $display("FAIL ram_kept_over_reset: got %h expected %h", d, 32'hDEADBEEF); end
    rd(32'h08, d);
    checks++;
    if (d !== 32'h22222222) begin errors++; $display("FAIL ram2_kept_over_reset: got %h expected %h", d, 32'h22222222); end
    resetn = 1'b1;
    tick();
    rd(32'hC8, d);
    checks++;
    if (d !== 32'h1) begin errors++; $display("FAIL cyc_after_release: got %h expected %h", d, 32'h1); end
  endtask

  initial begin
    resetn = 1'b0;
    we     = 1'b0;
    addr   = 32'h0;
    datain = 32'h0;
    sw     = 10'h0;
    test_reset();
    test_ram();
    test_hex_led();
    test_switch();
    test_set_beats_clear();
    test_counter_and_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
